// File: rtl/nios2_oci_trace_capture.sv
// OCI debug-trace capture buffer: records trace words, freezes on test end, drains oldest-first.
// Optional saturating lost-word counter enabled by OCI_TRACE_OVF_COUNT_EN.
module nios2_oci_trace_capture #(
    parameter int DATA_W    = 30,
    parameter int COUNT_W   = 4,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        capture_en,
    input  logic [DATA_W-1:0]           dct_buffer,
    input  logic [COUNT_W-1:0]          dct_count,
    input  logic                        dct_valid,
    input  logic                        test_ending,
    input  logic                        test_has_ended,
    input  logic                        rd_req,
    output logic [COUNT_W+DATA_W-1:0]   rd_data,
    output logic                        rd_valid,
    output logic                        rd_empty,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        overflow,
    output logic [1:0]                  state_o,
    output logic                        done
`ifdef OCI_TRACE_OVF_COUNT_EN
    ,
    output logic [15:0]                 ovf_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = COUNT_W + DATA_W;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CAP   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_occ;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [EW-1:0]   r_rd_data;
    logic            r_rd_valid;
    logic            w_wr;
    logic            w_full;
    logic            w_lost;
    logic            w_store;
    logic            w_rd;

    assign w_full  = (r_occ == L_FULL);
    assign w_wr    = (r_state == S_CAP) && dct_valid && (dct_count != '0);
    assign w_lost  = w_wr && w_full;
    // In wrap mode a full buffer still stores, evicting the oldest entry.
    assign w_store = w_wr && (!w_full || (WRAP_MODE != 0));
    assign w_rd    = (r_state == S_DRAIN) && rd_req && (r_occ != '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (capture_en && !test_ending) w_state_nxt = S_CAP;
            S_CAP:   if (test_ending || test_has_ended) w_state_nxt = S_DRAIN;
            S_DRAIN: if (test_has_ended && (r_occ == '0)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd;
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
            if (w_rd || (w_store && w_full)) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_store && !w_full) r_occ <= r_occ + 1'b1;
            else if (w_rd) r_occ <= r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_store) r_mem[r_wr_ptr] <= {dct_count, dct_buffer};
    end

`ifdef OCI_TRACE_OVF_COUNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) r_ovf_cnt <= '0;
        else if (w_lost && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end

    assign ovf_count = r_ovf_cnt;
    assign overflow  = (r_ovf_cnt != 16'd0);
`else
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (!reset_n) r_overflow <= 1'b0;
        else if (w_lost) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`endif

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_empty  = (r_occ == '0);
    assign occupancy = r_occ;
    assign state_o   = r_state;
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Scoreboard bench: wrap-mode and drop-mode instances share stimulus,
// each checked against a queue-based reference model.
module tb_nios2_oci_trace_capture;

    localparam int DW = 30;
    localparam int CW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic capture_en = 1'b0;
    logic [DW-1:0] dct_buffer = '0;
    logic [CW-1:0] dct_count = '0;
    logic dct_valid = 1'b0;
    logic test_ending = 1'b0;
    logic test_has_ended = 1'b0;
    logic rd_req = 1'b0;

    logic [1:0][CW+DW-1:0] rdd;
    logic [1:0] rv, emp, ovf, dn;
    logic [1:0][4:0] occ;
    logic [1:0][1:0] st;
`ifdef OCI_TRACE_OVF_COUNT_EN
    logic [1:0][15:0] ovc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_oci_trace_capture #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
        .rd_data(rdd[0]), .rd_valid(rv[0]), .rd_empty(emp[0]), .occupancy(occ[0]),
        .overflow(ovf[0]), .state_o(st[0]), .done(dn[0])
`ifdef OCI_TRACE_OVF_COUNT_EN
        , .ovf_count(ovc[0])
`endif
    );

    nios2_oci_trace_capture #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(0)) u_drop (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
        .rd_data(rdd[1]), .rd_valid(rv[1]), .rd_empty(emp[1]), .occupancy(occ[1]),
        .overflow(ovf[1]), .state_o(st[1]), .done(dn[1])
`ifdef OCI_TRACE_OVF_COUNT_EN
        , .ovf_count(ovc[1])
`endif
    );

    // Reference model: stored entries and expected pops per instance.
    logic [CW+DW-1:0] mq0[$], mq1[$], eq0[$], eq1[$];
    int ms[2];
    int movf[2];

    function automatic int qsz(int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic void qpush(int m, logic [CW+DW-1:0] x);
        if (m == 0) mq0.push_back(x);
        else mq1.push_back(x);
    endfunction

    function automatic logic [CW+DW-1:0] qpop(int m);
        if (m == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    function automatic void epush(int m, logic [CW+DW-1:0] x);
        if (m == 0) eq0.push_back(x);
        else eq1.push_back(x);
    endfunction

    function automatic void chk(string name, int m, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h", name, m, got, want);
        end
    endfunction

    function automatic void model_step(int m, bit wrap);
        int n = qsz(m);
        logic [CW+DW-1:0] x;
        if (!reset_n) begin
            if (m == 0) mq0.delete();
            else mq1.delete();
            ms[m] = 0;
            movf[m] = 0;
            return;
        end
        case (ms[m])
            0: if (capture_en && !test_ending) ms[m] = 1;
            1: begin
                if (dct_valid && dct_count != 0) begin
                    if (n < DEPTH) qpush(m, {dct_count, dct_buffer});
                    else begin
                        movf[m]++;
                        if (wrap) begin
                            x = qpop(m);
                            qpush(m, {dct_count, dct_buffer});
                        end
                    end
                end
                if (test_ending || test_has_ended) ms[m] = 2;
            end
            2: begin
                if (test_has_ended && n == 0) ms[m] = 3;
                if (rd_req && n > 0) epush(m, qpop(m));
            end
            default: ;
        endcase
    endfunction

    function automatic void check_status(int m);
        int n = qsz(m);
        chk("occupancy", m, occ[m], n);
        chk("state", m, st[m], ms[m]);
        chk("rd_empty", m, emp[m], (n == 0) ? 1 : 0);
        chk("overflow", m, ovf[m], (movf[m] > 0) ? 1 : 0);
        chk("done", m, dn[m], (ms[m] == 3) ? 1 : 0);
`ifdef OCI_TRACE_OVF_COUNT_EN
        chk("ovf_count", m, ovc[m], (movf[m] > 65535) ? 65535 : movf[m]);
`endif
    endfunction

    // Monitors: every rd_valid pulse must match the oldest expected pop.
    always @(posedge clk) begin
        #1;
        if (rv[0]) begin
            if (eq0.size() == 0) chk("rd_valid_unexpected", 0, 1, 0);
            else chk("rd_data", 0, rdd[0], eq0.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (rv[1]) begin
            if (eq1.size() == 0) chk("rd_valid_unexpected", 1, 1, 0);
            else chk("rd_data", 1, rdd[1], eq1.pop_front());
        end
    end

    task automatic cyc();
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        @(posedge clk);
        #1;
        check_status(0);
        check_status(1);
        reset_n = 1'b1;
        capture_en = 1'b0;
        dct_valid = 1'b0;
        test_ending = 1'b0;
        test_has_ended = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
    endtask

    task automatic wr(int data, int cnt);
        dct_valid = 1'b1;
        dct_buffer = DW'(data);
        dct_count = CW'(cnt);
    endtask

    initial begin
        do_reset();
        do_reset();
        // basic capture/drain
        dct_valid = 1'b1;
        dct_count = 4'd4;
        cyc();
        capture_en = 1'b1;
        cyc();
        for (int i = 1; i <= 5; i++) begin
            wr(i, 4);
            cyc();
        end
        rd_req = 1'b1;
        cyc();
        test_ending = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            cyc();
        end
        cyc();
        test_has_ended = 1'b1;
        cyc();
        cyc();
        rd_req = 1'b1;
        cyc();
        cyc();
        // overflow in both modes
        do_reset();
        capture_en = 1'b1;
        cyc();
        for (int i = 1; i <= 20; i++) begin
            wr(i, $urandom_range(1, 15));
            cyc();
        end
        test_ending = 1'b1;
        cyc();
        for (int i = 0; i < 18; i++) begin
            rd_req = 1'b1;
            cyc();
        end
        cyc();
        // simultaneous events and DONE gating
        do_reset();
        capture_en = 1'b1;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            wr(i + 100, 2);
            cyc();
        end
        wr(200, 3);
        test_ending = 1'b1;
        cyc();
        wr(201, 3);
        cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b1;
        cyc();
        test_has_ended = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            rd_req = 1'b1;
            test_has_ended = 1'b1;
            cyc();
        end
        test_has_ended = 1'b1;
        cyc();
        rd_req = 1'b1;
        cyc();
        cyc();
        // reset during drain
        do_reset();
        capture_en = 1'b1;
        cyc();
        for (int i = 1; i <= 9; i++) begin
            wr(i + 300, 5);
            cyc();
        end
        test_ending = 1'b1;
        cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b1;
        cyc();
        cyc();
        reset_n = 1'b0;
        rd_req = 1'b1;
        cyc();
        cyc();
        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            capture_en = 1'b1;
            dct_valid = 1'b1;
            dct_count = 4'd1;
            cyc();
            for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
                dct_valid = 1'($urandom());
                dct_count = CW'($urandom_range(0, 15));
                dct_buffer = DW'($urandom());
                rd_req = 1'($urandom());
                test_has_ended = ($urandom_range(0, 49) == 0);
                cyc();
            end
            test_ending = 1'b1;
            cyc();
            for (int c = 0; c < 30; c++) begin
                rd_req = ($urandom_range(0, 3) != 0);
                test_has_ended = ($urandom_range(0, 3) == 0);
                reset_n = ($urandom_range(0, 99) != 0);
                dct_valid = 1'($urandom());
                dct_count = CW'($urandom_range(1, 15));
                capture_en = 1'($urandom());
                cyc();
            end
        end
        cyc();
        cyc();
        chk("pending_pops", 0, eq0.size(), 0);
        chk("pending_pops", 1, eq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
